// File: rtl/xvc_jtag_shifter_pkg.sv
// Shared types and helpers for the XVC JTAG shifter.
// Header size, default widths, FSM states and byte-count helper.
package xvc_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_LEN_W  = 9;
   localparam int HDR_BYTES  = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_CHECK,
      S_LOAD,
      S_SHIFT,
      S_STORE,
      S_COMMIT,
      S_DROP
   } state_t;

   function automatic logic [29:0] nbytes(
      input logic [31:0] n
   );
      return {1'b0, n[31:3]} + {29'd0, |n[2:0]};
   endfunction

endpackage

// File: rtl/xvc_jtag_shifter_if.sv
// Packet-buffer read side and result-buffer write side.
// master = shifter, slave = buffers.
interface xvc_jtag_shifter_if #(
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 9
);

   logic              in_avail;
   logic [LEN_W-1:0]  in_len;
   logic [ADDR_W-1:0] in_addr;
   logic [7:0]        in_data;
   logic              in_next;
   logic              out_ready;
   logic              out_we;
   logic [ADDR_W-1:0] out_addr;
   logic [7:0]        out_data;
   logic              out_commit;
   logic [LEN_W-1:0]  out_len;

   modport master (
      input  in_avail, in_len, in_data, out_ready,
      output in_addr, in_next,
      output out_we, out_addr, out_data,
      output out_commit, out_len
   );

   modport slave (
      output in_avail, in_len, in_data, out_ready,
      input  in_addr, in_next,
      input  out_we, out_addr, out_data,
      input  out_commit, out_len
   );

endinterface

// File: rtl/xvc_jtag_shifter_tck_gen.sv
// TCK generator: high and low phases of half clocks each.
// rise/fall flag the system-clock edge on which tck toggles.
module jtag_tck_gen (
   input  logic        clock,
   input  logic        reset,
   input  logic        run,
   input  logic [15:0] half,
   output logic        tck,
   output logic        rise,
   output logic        fall
);

   logic [15:0] cnt;
   logic        tick;

   assign tick = run && (cnt == 16'd0);
   assign rise = tick && !tck;
   assign fall = tick && tck;

   // Dropping run parks tck low and rearms an immediate rise.
   always_ff @(posedge clock) begin
      if (!reset || !run) begin
         tck <= 1'b0;
         cnt <= 16'd0;
      end else if (tick) begin
         tck <= !tck;
         cnt <= half - 16'd1;
      end else begin
         cnt <= cnt - 16'd1;
      end
   end

endmodule

// File: rtl/xvc_jtag_shifter.sv
// XVC shift engine: reads one shift: payload, clocks it out
// on JTAG and writes the captured TDO bytes as a result packet.
module xvc_jtag_shifter
   import xvc_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int LEN_W     = DEF_LEN_W,
   parameter int MAX_BYTES = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] tck_half,
   xvc_jtag_shifter_if.master bus,
   output logic        jtag_tck,
   output logic        jtag_tms,
   output logic        jtag_tdi,
   input  logic        jtag_tdo,
   output logic        busy,
   output logic        err_len
);

   state_t            st;
   logic [15:0]       half;
   logic [2:0]        cnt;
   logic [31:0]       nbits;
   logic [LEN_W-1:0]  nb;
   logic [LEN_W-1:0]  idx;
   logic [9:0]        rem;
   logic [3:0]        vbits;
   logic [2:0]        bidx;
   logic [7:0]        tms_b;
   logic [7:0]        tdi_b;
   logic [7:0]        tdo_b;
   logic              run;
   logic              rise;
   logic              fall;
   logic [29:0]       nb_full;
   logic [LEN_W:0]    len_need;
   logic              bad;

   assign run      = (st == S_SHIFT);
   assign nb_full  = nbytes(nbits);
   assign len_need = (LEN_W+1)'(HDR_BYTES)
                   + {nb_full[LEN_W-1:0], 1'b0};
   assign bad      = (nb_full > 30'(MAX_BYTES))
                  || ({1'b0, bus.in_len} != len_need);

   jtag_tck_gen u_tck (
      .clock (clock),
      .reset (reset),
      .run   (run),
      .half  (half),
      .tck   (jtag_tck),
      .rise  (rise),
      .fall  (fall)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         st             <= S_IDLE;
         bus.in_addr    <= '0;
         bus.in_next    <= 1'b0;
         bus.out_we     <= 1'b0;
         bus.out_addr   <= '0;
         bus.out_data   <= '0;
         bus.out_commit <= 1'b0;
         bus.out_len    <= '0;
         jtag_tms       <= 1'b1;
         jtag_tdi       <= 1'b0;
         busy           <= 1'b0;
         err_len        <= 1'b0;
         half           <= 16'd1;
         cnt            <= '0;
         nbits          <= '0;
         nb             <= '0;
         idx            <= '0;
         rem            <= '0;
         vbits          <= '0;
         bidx           <= '0;
         tms_b          <= '0;
         tdi_b          <= '0;
         tdo_b          <= '0;
      end else begin
         bus.in_next    <= 1'b0;
         bus.out_we     <= 1'b0;
         bus.out_commit <= 1'b0;
         unique case (st)
            S_IDLE: begin
               if (bus.in_avail && bus.out_ready) begin
                  busy        <= 1'b1;
                  err_len     <= 1'b0;
                  half        <= (tck_half == 16'd0) ? 16'd1 : tck_half;
                  bus.in_addr <= '0;
                  cnt         <= '0;
                  st          <= S_HDR;
               end
            end
            // Byte k arrives two edges after its address is issued.
            S_HDR: begin
               bus.in_addr <= bus.in_addr + ADDR_W'(1);
               cnt         <= cnt + 3'd1;
               if (cnt != 3'd0)
                  nbits <= {bus.in_data, nbits[31:8]};
               if (cnt == 3'd4)
                  st <= S_CHECK;
            end
            S_CHECK: begin
               nb  <= nb_full[LEN_W-1:0];
               rem <= nbits[9:0];
               idx <= '0;
               if (bad) begin
                  st          <= S_DROP;
                  bus.in_next <= 1'b1;
                  err_len     <= 1'b1;
               end else if (nb_full == 30'd0) begin
                  st             <= S_COMMIT;
                  bus.out_commit <= 1'b1;
                  bus.in_next    <= 1'b1;
                  bus.out_len    <= '0;
               end else begin
                  st          <= S_LOAD;
                  cnt         <= '0;
                  bus.in_addr <= ADDR_W'(HDR_BYTES);
               end
            end
            S_DROP: begin
               busy <= 1'b0;
               st   <= S_IDLE;
            end
            S_LOAD: begin
               cnt <= cnt + 3'd1;
               if (cnt == 3'd0)
                  bus.in_addr <= ADDR_W'(HDR_BYTES)
                               + ADDR_W'(nb) + ADDR_W'(idx);
               if (cnt == 3'd1)
                  tms_b <= bus.in_data;
               if (cnt == 3'd2) begin
                  tdi_b    <= bus.in_data;
                  tdo_b    <= '0;
                  bidx     <= '0;
                  vbits    <= (rem >= 10'd8) ? 4'd8 : rem[3:0];
                  jtag_tms <= tms_b[0];
                  jtag_tdi <= bus.in_data[0];
                  st       <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (rise) begin
                  tdo_b[bidx] <= jtag_tdo;
                  rem         <= rem - 10'd1;
               end
               if (fall) begin
                  if ({1'b0, bidx} + 4'd1 == vbits) begin
                     st           <= S_STORE;
                     bus.out_we   <= 1'b1;
                     bus.out_addr <= ADDR_W'(idx);
                     bus.out_data <= tdo_b;
                  end else begin
                     bidx     <= bidx + 3'd1;
                     jtag_tms <= tms_b[bidx + 3'd1];
                     jtag_tdi <= tdi_b[bidx + 3'd1];
                  end
               end
            end
            S_STORE: begin
               idx <= idx + LEN_W'(1);
               if (idx + LEN_W'(1) == nb) begin
                  st             <= S_COMMIT;
                  bus.out_commit <= 1'b1;
                  bus.in_next    <= 1'b1;
                  bus.out_len    <= nb;
               end else begin
                  st          <= S_LOAD;
                  cnt         <= '0;
                  bus.in_addr <= ADDR_W'(HDR_BYTES)
                               + ADDR_W'(idx) + ADDR_W'(1);
               end
            end
            S_COMMIT: begin
               busy <= 1'b0;
               st   <= S_IDLE;
            end
            default: st <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xvc_jtag_shifter.sv
// Bench for xvc_jtag_shifter: packet buffer model, TDO loopback,
// bit-stream scoreboard checked every cycle plus directed literals.
module tb_xvc_jtag_shifter;

   localparam int AW = 8;
   localparam int LW = 9;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] tck_half = 16'd1;
   logic        jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;
   logic        busy, err_len;
   logic        tdo_inv = 1'b0;

   always #5 clock = ~clock;

   xvc_jtag_shifter_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();

   xvc_jtag_shifter #(
      .ADDR_W(AW), .LEN_W(LW), .MAX_BYTES(64)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .tck_half (tck_half),
      .bus      (bus),
      .jtag_tck (jtag_tck),
      .jtag_tms (jtag_tms),
      .jtag_tdi (jtag_tdi),
      .jtag_tdo (jtag_tdo),
      .busy     (busy),
      .err_len  (err_len)
   );

   assign jtag_tdo = jtag_tdi ^ tdo_inv;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // packet buffer: queue of packets over a flat byte store
   logic [7:0] mem [0:4095];
   int wptr = 0;
   int hb = 0;
   int q_base[$];
   int q_len[$];

   always @(posedge clock) begin
      bus.in_data <= mem[(hb + int'(bus.in_addr)) % 4096];
      if (bus.in_next && q_len.size() > 0) begin
         q_base.delete(0);
         q_len.delete(0);
      end
      if (q_len.size() > 0) begin
         hb           <= q_base[0];
         bus.in_avail <= 1'b1;
         bus.in_len   <= LW'(q_len[0]);
      end else begin
         bus.in_avail <= 1'b0;
         bus.in_len   <= '0;
      end
   end

   // expected behaviour: bit stream, result writes, commit lengths
   logic [1:0]  exp_bits[$];
   logic [15:0] exp_we[$];
   int          exp_len[$];
   int          exp_half = 1;

   task automatic push_model(input int nbits,
                             input logic [63:0] tms,
                             input logic [63:0] tdi,
                             input int len,
                             input logic inv,
                             input int half);
      int nb;
      logic [63:0] res;
      nb = (nbits + 7) / 8;
      res = '0;
      exp_half = (half == 0) ? 1 : half;
      if (nb <= 64 && len == 4 + 2 * nb) begin
         for (int k = 0; k < nbits; k++) begin
            exp_bits.push_back({tms[k], tdi[k]});
            res[k] = tdi[k] ^ inv;
         end
         for (int i = 0; i < nb; i++)
            exp_we.push_back({8'(i), res[8*i +: 8]});
         exp_len.push_back(nb);
      end
   endtask

   task automatic push_mem(input int nbits,
                           input logic [63:0] tms,
                           input logic [63:0] tdi,
                           input int len);
      int nb;
      nb = (nbits + 7) / 8;
      q_base.push_back(wptr);
      q_len.push_back(len);
      for (int b = 0; b < 4; b++)
         mem[wptr + b] = 8'(nbits >> (8 * b));
      for (int i = 0; i < nb; i++) begin
         mem[wptr + 4 + i]      = tms[8*i +: 8];
         mem[wptr + 4 + nb + i] = tdi[8*i +: 8];
      end
      wptr += 4 + 2 * nb;
   endtask

   task automatic send(input int nbits,
                       input logic [63:0] tms,
                       input logic [63:0] tdi,
                       input int len,
                       input logic inv,
                       input int half);
      push_model(nbits, tms, tdi, len, inv, half);
      push_mem(nbits, tms, tdi, len);
   endtask

   // compare process
   int cyc = 0;
   int rise_cyc = 0;
   int fall_cyc = 0;
   int last_hi = 0;
   int last_lo = 0;
   int n_rise = 0;
   int n_we = 0;
   int n_commit = 0;
   int n_next = 0;
   int last_len = -1;
   logic [7:0]  res_mem [0:63];
   logic        p_tck = 1'b0;
   logic        p_tms = 1'b1;
   logic        p_tdi = 1'b0;
   logic [1:0]  eb;
   logic [15:0] ew;

   always @(negedge clock) begin
      cyc <= cyc + 1;
      if (reset) begin
         if (jtag_tck && !p_tck) begin
            n_rise   <= n_rise + 1;
            last_lo  <= cyc - fall_cyc;
            rise_cyc <= cyc;
            if (exp_bits.size() == 0) begin
               chk("tck_rise_expected", 1, 0);
            end else begin
               eb = exp_bits.pop_front();
               chk("tms_at_rise", jtag_tms, eb[1]);
               chk("tdi_at_rise", jtag_tdi, eb[0]);
            end
         end
         if (!jtag_tck && p_tck) begin
            fall_cyc <= cyc;
            last_hi  <= cyc - rise_cyc;
            chk("tck_high_clocks", cyc - rise_cyc, exp_half);
         end
         if (jtag_tms !== p_tms || jtag_tdi !== p_tdi)
            chk("tms_tdi_change_tck_low", jtag_tck, 0);
         if (bus.out_we) begin
            n_we <= n_we + 1;
            res_mem[bus.out_addr[5:0]] <= bus.out_data;
            if (exp_we.size() == 0) begin
               chk("out_we_expected", 1, 0);
            end else begin
               ew = exp_we.pop_front();
               chk("out_addr", bus.out_addr, ew[15:8]);
               chk("out_data", bus.out_data, ew[7:0]);
            end
         end
         if (bus.out_commit) begin
            n_commit <= n_commit + 1;
            last_len <= int'(bus.out_len);
            chk("in_next_with_commit", bus.in_next, 1);
            if (exp_len.size() == 0)
               chk("commit_expected", 1, 0);
            else
               chk("out_len", bus.out_len, exp_len.pop_front());
         end
         if (bus.in_next)
            n_next <= n_next + 1;
      end
      p_tck <= jtag_tck;
      p_tms <= jtag_tms;
      p_tdi <= jtag_tdi;
   end

   int r0, w0, c0, x0;

   task automatic snap();
      r0 = n_rise;
      w0 = n_we;
      c0 = n_commit;
      x0 = n_next;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic wait_next(input string nm);
      int t;
      t = 0;
      while (n_next <= x0 && t < 3000) begin
         tick(1);
         t++;
      end
      chk({nm, "_done"}, n_next > x0, 1);
      tick(2);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int t;
      logic seen;
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      for (int i = 0; i < 64; i++) res_mem[i] = 8'h00;
      bus.out_ready = 1'b1;
      reset = 1'b0;
      tick(3);
      chk("rst_tck", jtag_tck, 0);
      chk("rst_tms", jtag_tms, 1);
      chk("rst_tdi", jtag_tdi, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_len, 0);
      chk("rst_in_next", bus.in_next, 0);
      chk("rst_out_we", bus.out_we, 0);
      chk("rst_commit", bus.out_commit, 0);
      chk("rst_out_len", bus.out_len, 0);
      chk("rst_in_addr", bus.in_addr, 0);
      chk("rst_out_addr", bus.out_addr, 0);
      reset = 1'b1;
      tick(2);

      snap();
      send(8, 64'h00, 64'hA5, 6, 1'b0, 1);
      wait_next("t1");
      chk("t1_rises", n_rise - r0, 8);
      chk("t1_we", n_we - w0, 1);
      chk("t1_commit", n_commit - c0, 1);
      chk("t1_in_next", n_next - x0, 1);
      chk("t1_data", res_mem[0], 8'hA5);
      chk("t1_len", last_len, 1);
      chk("t1_busy", busy, 0);

      snap();
      send(12, 64'h0, 64'hFFFF, 8, 1'b0, 1);
      wait_next("t2");
      chk("t2_rises", n_rise - r0, 12);
      chk("t2_byte0", res_mem[0], 8'hFF);
      chk("t2_byte1", res_mem[1], 8'h0F);
      chk("t2_len", last_len, 2);

      snap();
      tck_half = 16'd3;
      send(8, 64'h3C, 64'h96, 6, 1'b0, 3);
      tick(4);
      chk("t3_busy_accept", busy, 1);
      tck_half = 16'd1;
      wait_next("t3");
      chk("t3_rises", n_rise - r0, 8);
      chk("t3_high", last_hi, 3);
      chk("t3_low", last_lo, 3);
      chk("t3_data", res_mem[0], 8'h96);

      snap();
      send(8, 64'h00, 64'h5A, 5, 1'b0, 1);
      wait_next("t4");
      chk("t4_err", err_len, 1);
      chk("t4_rises", n_rise - r0, 0);
      chk("t4_we", n_we - w0, 0);
      chk("t4_commit", n_commit - c0, 0);
      chk("t4_in_next", n_next - x0, 1);
      chk("t4_busy", busy, 0);

      snap();
      bus.out_ready = 1'b0;
      send(0, 64'h0, 64'h0, 4, 1'b0, 1);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (busy !== 1'b0) seen = 1'b1;
      end
      chk("t5_idle_busy", seen, 0);
      chk("t5_idle_next", n_next - x0, 0);
      bus.out_ready = 1'b1;
      tick(1);
      chk("t5_busy_accept", busy, 1);
      chk("t5_err_cleared", err_len, 0);
      wait_next("t5");
      chk("t5_len", last_len, 0);
      chk("t5_rises", n_rise - r0, 0);
      chk("t5_we", n_we - w0, 0);
      chk("t5_commit", n_commit - c0, 1);

      snap();
      tdo_inv = 1'b1;
      send(5, 64'h1F, 64'h0A, 6, 1'b1, 1);
      wait_next("t6");
      chk("t6_data", res_mem[0], 8'h15);
      chk("t6_rises", n_rise - r0, 5);
      tdo_inv = 1'b0;

      snap();
      send(16, 64'hA5C3, 64'h1234, 8, 1'b0, 1);
      t = 0;
      while (n_rise - r0 < 5 && t < 500) begin
         tick(1);
         t++;
      end
      chk("t7_shifting", n_rise - r0 >= 5, 1);
      reset = 1'b0;
      tick(1);
      chk("t7_rst_tck", jtag_tck, 0);
      chk("t7_rst_tms", jtag_tms, 1);
      chk("t7_rst_busy", busy, 0);
      tick(2);
      chk("t7_no_commit", n_commit - c0, 0);
      chk("t7_no_next", n_next - x0, 0);
      exp_bits.delete();
      exp_we.delete();
      exp_len.delete();
      push_model(16, 64'hA5C3, 64'h1234, 8, 1'b0, 1);
      snap();
      reset = 1'b1;
      wait_next("t7");
      chk("t7_rises", n_rise - r0, 16);
      chk("t7_byte0", res_mem[0], 8'h34);
      chk("t7_byte1", res_mem[1], 8'h12);
      chk("t7_len", last_len, 2);
      chk("t7_in_next", n_next - x0, 1);

      chk("model_drained",
          exp_bits.size() + exp_we.size() + exp_len.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
